fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of entries; SHALL be a power of two >= 2.
REQ-002 Parameter PC_W, default 48, fetch address width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 n_reset  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  discard all entries (driven by mispred_ex).
REQ-006 enq_valid  input  1  fetch stage presents an instruction.
REQ-007 enq_pc  input  PC_W  fetch address of the instruction.
REQ-008 enq_instr  input  32  fetched instruction word.
REQ-009 enq_trap  input  1  misaligned-fetch trap flag from fetch.
REQ-010 enq_ready  output  1  queue accepts; drives the fetch stage ready input.
REQ-011 deq_valid  output  1  head entry valid for decode.
REQ-012 deq_pc  output  PC_W  head entry address.
REQ-013 deq_instr  output  32  head entry instruction.
REQ-014 deq_trap  output  1  head entry trap flag.
REQ-015 deq_ready  input  1  decode consumes head this cycle.
REQ-016 count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-017 Enqueue SHALL occur when enq_valid && enq_ready && !flush; entry written at tail, tail advances.
REQ-018 Dequeue SHALL occur when deq_valid && deq_ready && !flush; head advances.
REQ-019 enq_ready SHALL equal (count < DEPTH) && !trap_hold; it SHALL NOT depend on deq_ready (no same-cycle pass-through when full).
REQ-020 deq_valid SHALL equal (count != 0); no bypass: an entry enqueued in cycle N is visible at the head no earlier than cycle N+1.
REQ-021 deq_pc, deq_instr, deq_trap SHALL show the head entry when deq_valid=1 and SHALL be all-zero when deq_valid=0.
REQ-022 Simultaneous enqueue and dequeue SHALL leave count unchanged; permitted when full only if enq_ready=1, which it is not, so full+dequeue frees one slot for the next cycle.
REQ-023 Head and tail pointers SHALL wrap modulo DEPTH; order SHALL be strict FIFO.
REQ-024 count SHALL increment by 1 on enqueue-only, decrement by 1 on dequeue-only, never exceed DEPTH or go below 0.
REQ-025 trap_hold SHALL set on enqueue of an entry with enq_trap=1 and clear only on flush or reset; while set, no further entries are accepted.
REQ-026 flush SHALL, on the next edge, empty the queue (count=0, pointers=0, trap_hold=0) and discard any same-cycle enqueue and dequeue.
REQ-027 Entries already dequeued before a flush SHALL be unaffected; flush has priority over all other events.

Reset
REQ-028 On n_reset low: count=0, head=tail=0, trap_hold=0, deq_valid=0, deq_* outputs zero, enq_ready=1 after release.
REQ-029 Reset mid-operation SHALL discard all entries immediately and asynchronously; storage array contents need not be reset.

Structure
REQ-030 Shared package SHALL hold PC_W default constant and typedef fetch_entry_t {pc[PC_W], instr[32], trap}, reused by decode.
REQ-031 Single module; storage is a flop array of fetch_entry_t, no sub-module.

Verification
REQ-032 Fill: enqueue pc 0x0,0x4,0x8,0xC, deq_ready=0 -> count=4, enq_ready=0, deq_pc=0x0.
REQ-033 Drain in order: deq_ready=1 for 4 cycles -> deq_pc 0x0,0x4,0x8,0xC, then deq_valid=0, outputs zero.
REQ-034 Wrap: 10 back-to-back enq/deq with DEPTH=4 -> count steady at 1, FIFO order preserved across pointer wrap.
REQ-035 Flush with count=3 and enq_valid=1 same cycle -> next cycle count=0, deq_valid=0, enqueued entry absent.
REQ-036 Trap: enqueue pc 0x2 with enq_trap=1 -> enq_ready=0 until flush; deq_trap=1 at head.
REQ-037 Async reset asserted with count=2 -> deq_valid=0 and count=0 before next clk edge.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path types: the entry format carried from fetch into decode.
package fetch_queue_pkg;

  localparam int FETCH_PC_W = 48;

  typedef struct packed {
    logic [FETCH_PC_W-1:0] pc;
    logic [31:0]           instr;
    logic                  trap;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: strict FIFO with no bypass, flush, and a
// trap hold that stops intake after a faulting fetch until the pipe is flushed.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = FETCH_PC_W
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     flush,
  input  logic                     enq_valid,
  input  logic [PC_W-1:0]          enq_pc,
  input  logic [31:0]              enq_instr,
  input  logic                     enq_trap,
  output logic                     enq_ready,
  output logic                     deq_valid,
  output logic [PC_W-1:0]          deq_pc,
  output logic [31:0]              deq_instr,
  output logic                     deq_trap,
  input  logic                     deq_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  fetch_entry_t     head_entry;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count_q;
  logic             trap_hold;
  logic             do_enq;
  logic             do_deq;

  // Ready deliberately ignores deq_ready so a full queue never passes through.
  assign enq_ready = (count_q < CNT_W'(DEPTH)) && !trap_hold;
  assign deq_valid = (count_q != '0);
  assign do_enq    = enq_valid && enq_ready && !flush;
  assign do_deq    = deq_valid && deq_ready && !flush;
  assign count     = count_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      head      <= '0;
      tail      <= '0;
      count_q   <= '0;
      trap_hold <= 1'b0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count_q   <= '0;
      trap_hold <= 1'b0;
    end else begin
      if (do_enq) begin
        tail <= tail + 1'b1;
        if (enq_trap) trap_hold <= 1'b1;
      end
      if (do_deq) head <= head + 1'b1;
      if (do_enq && !do_deq) count_q <= count_q + 1'b1;
      else if (!do_enq && do_deq) count_q <= count_q - 1'b1;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      mem[tail].pc    <= FETCH_PC_W'(enq_pc);
      mem[tail].instr <= enq_instr;
      mem[tail].trap  <= enq_trap;
    end
  end

  always_comb begin
    head_entry = '0;
    if (deq_valid) head_entry = mem[head];
  end

  assign deq_pc    = PC_W'(head_entry.pc);
  assign deq_instr = head_entry.instr;
  assign deq_trap  = head_entry.trap;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill, drain, wrap, flush, trap hold, async reset.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 48;

  logic              clk = 1'b0;
  logic              n_reset;
  logic              flush;
  logic              enq_valid;
  logic [PC_W-1:0]   enq_pc;
  logic [31:0]       enq_instr;
  logic              enq_trap;
  logic              enq_ready;
  logic              deq_valid;
  logic [PC_W-1:0]   deq_pc;
  logic [31:0]       deq_instr;
  logic              deq_trap;
  logic              deq_ready;
  logic [2:0]        count;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_pc    (enq_pc),
    .enq_instr (enq_instr),
    .enq_trap  (enq_trap),
    .enq_ready (enq_ready),
    .deq_valid (deq_valid),
    .deq_pc    (deq_pc),
    .deq_instr (deq_instr),
    .deq_trap  (deq_trap),
    .deq_ready (deq_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ev, input logic [PC_W-1:0] pc, input logic trap,
                       input logic dr, input logic fl);
    enq_valid = ev;
    enq_pc    = pc;
    enq_instr = 32'hA500_0000 | 32'(pc);
    enq_trap  = trap;
    deq_ready = dr;
    flush     = fl;
  endtask

  initial begin
    n_reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #12;
    check("rst_count", 64'(count), 64'd0);
    check("rst_deq_valid", 64'(deq_valid), 64'd0);
    check("rst_deq_pc", 64'(deq_pc), 64'd0);
    check("rst_deq_trap", 64'(deq_trap), 64'd0);
    n_reset = 1'b1;
    tick();
    check("rst_enq_ready", 64'(enq_ready), 64'd1);

    // Fill with pc 0x0,0x4,0x8,0xC, decode stalled
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, PC_W'(4 * i), 1'b0, 1'b0, 1'b0);
      if (i == 0) check("no_bypass_valid", 64'(deq_valid), 64'd0);
      tick();
      check("fill_count", 64'(count), 64'(i + 1));
    end
    check("full_enq_ready", 64'(enq_ready), 64'd0);
    check("full_deq_pc", 64'(deq_pc), 64'h0);
    check("full_deq_instr", 64'(deq_instr), 64'hA500_0000);
    // Full: enq attempt with dequeue must not pass through
    drive(1'b1, PC_W'('h10), 1'b0, 1'b1, 1'b0);
    check("full_ready_with_deq", 64'(enq_ready), 64'd0);
    tick();
    check("full_deq_frees_slot", 64'(count), 64'd3);
    check("freed_enq_ready", 64'(enq_ready), 64'd1);
    check("freed_head_pc", 64'(deq_pc), 64'h4);

    // Drain remaining
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      check("drain_pc", 64'(deq_pc), 64'(4 * i));
      check("drain_instr", 64'(deq_instr), 64'hA500_0000 | 64'(4 * i));
      tick();
    end
    check("empty_valid", 64'(deq_valid), 64'd0);
    check("empty_pc_zero", 64'(deq_pc), 64'd0);
    check("empty_instr_zero", 64'(deq_instr), 64'd0);
    check("empty_count", 64'(count), 64'd0);

    // Wrap: one entry primed then 10 back-to-back enq/deq
    drive(1'b1, PC_W'('h100), 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, PC_W'('h104 + 4 * i), 1'b0, 1'b1, 1'b0);
      check("wrap_head_pc", 64'(deq_pc), 64'('h100 + 4 * i));
      tick();
      check("wrap_count", 64'(count), 64'd1);
    end
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("wrap_last_pc", 64'(deq_pc), 64'h128);
    tick();
    check("wrap_empty", 64'(count), 64'd0);

    // Flush with three entries plus a same-cycle enqueue and dequeue
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, PC_W'('h200 + 4 * i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("preflush_count", 64'(count), 64'd3);
    drive(1'b1, PC_W'('h20C), 1'b0, 1'b1, 1'b1);
    tick();
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(deq_valid), 64'd0);
    check("flush_pc_zero", 64'(deq_pc), 64'd0);
    drive(1'b1, PC_W'('h300), 1'b0, 1'b0, 1'b0);
    tick();
    check("postflush_head", 64'(deq_pc), 64'h300);
    check("postflush_count", 64'(count), 64'd1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    tick();

    // Trap hold
    drive(1'b1, PC_W'('h2), 1'b1, 1'b0, 1'b0);
    tick();
    check("trap_enq_ready", 64'(enq_ready), 64'd0);
    check("trap_deq_trap", 64'(deq_trap), 64'd1);
    check("trap_deq_pc", 64'(deq_pc), 64'h2);
    drive(1'b1, PC_W'('h6), 1'b0, 1'b0, 1'b0);
    tick();
    check("trap_blocks_enq", 64'(count), 64'd1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    tick();
    check("trap_drained", 64'(count), 64'd0);
    check("trap_hold_after_drain", 64'(enq_ready), 64'd0);
    check("trap_flag_cleared", 64'(deq_trap), 64'd0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    check("trap_flush_ready", 64'(enq_ready), 64'd1);

    // Async reset mid-cycle with two entries held
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, PC_W'('h400 + 4 * i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("prereset_count", 64'(count), 64'd2);
    #2;
    n_reset = 1'b0;
    #1;
    check("async_rst_valid", 64'(deq_valid), 64'd0);
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_pc", 64'(deq_pc), 64'd0);
    #3;
    n_reset = 1'b1;
    tick();
    check("post_rst_ready", 64'(enq_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
